pd_axis_sched: RTL
==================

// Module: pd_axis_sched
// PURPOSE
//  Time-multiplexes one PD arithmetic unit across pitch, roll and yaw.
//  On each valid inertial sample it snapshots desired/actual angles and runs the three axes in turn.
//  It keeps a per-axis error history queue and publishes registered pterm/dterm per axis with a one-cycle done strobe.
//  Sits between the inertial interface and the motor-mix/saturation stage of flight control.
// PARAMETERS
//  D_QUEUE_DEPTH  12  samples back used as previous error for the D term (2..16)
//  D_COEFF        7   D-term multiplier (5-bit signed constant)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  vld          in   1   new inertial sample valid this cycle
//  clr_hist     in   1   synchronous clear of history and pending sample; aborts the current run
//  d_ptch/d_roll/d_yaw  in  16  desired angles, signed
//  ptch/roll/yaw        in  16  actual angles, signed
//  ptch_pterm/roll_pterm/yaw_pterm  out  10  signed P terms
//  ptch_dterm/roll_dterm/yaw_dterm  out  12  signed D terms
//  terms_vld    out  1   one-cycle pulse: all six term outputs updated
//  busy         out  1   high while state != IDLE
//  ovr          out  1   sticky flag: a pending sample was overwritten; cleared only by rst
// BEHAVIOUR
//  Reset: every output 0, all queue entries 0, state IDLE, pending=0.
//  Arithmetic, per axis:
//   - err = desired - actual, computed at 17 bits.
//   - err_sat = saturate(err) to 10-bit signed, range -512..511.
//   - pterm = (err_sat>>>1) + (err_sat>>>3), arithmetic shifts (= 5/8 * err_sat).
//   - diff = err_sat - prev_err (11 bits), then saturated to 7-bit signed, range -64..63.
//   - dterm = diff_sat * D_COEFF, 12-bit signed.
//   - prev_err = the axis's err_sat from D_QUEUE_DEPTH processed samples earlier; 0 until the queue has filled.
//  FSM states: IDLE, ERR, TERM, DONE. Axis index ax runs 0=ptch, 1=roll, 2=yaw.
//   - IDLE: vld -> capture snapshot; ax=0; go to ERR.
//   - ERR: compute err_sat and read queue[ax] tail into a pipeline register.
//   - TERM: compute pterm/dterm into result registers; push err_sat into queue[ax].
//     ax<2 -> ax+1, ERR. ax==2 -> DONE.
//   - DONE: terms_vld=1 and all six outputs update together.
//     pending=1 -> load pending snapshot, clear pending, ax=0, ERR. Otherwise -> IDLE.
//  Latency: vld in cycle N -> terms_vld in cycle N+7. Outputs hold between pulses.
//  vld while busy (including the DONE cycle): snapshot goes to the pending register and pending=1.
//   If pending is already 1, the newer sample overwrites it and ovr sets.
//  A pending sample starts its ERR in the cycle after DONE, so results arrive back-to-back 7 cycles apart.
//  clr_hist, at any time:
//   - queues zeroed, pending=0, state -> IDLE, no terms_vld for an aborted run.
//   - term outputs keep their last values.
//   - vld in the same cycle is ignored.
//  rst overrides clr_hist and vld.
//  The queue advances only on processed samples, one push per axis per run. An aborted run pushes nothing.
// STRUCTURE
//  Package flght_pkg: axis_t enum (AX_PTCH/AX_ROLL/AX_YAW), sched_state_t enum, and width constants:
//   ERR_W=10, PTERM_W=10, DTERM_W=12, DIFF_W=7, plus the saturation limits.
//  Sub-module pd_axis_math: combinational err_sat, diff_sat, pterm, dterm from (desired, actual, prev_err).
//   Instantiated once and fed from the snapshot mux by ax.
//  Queues: 3 x D_QUEUE_DEPTH x 10-bit circular buffers sharing one write pointer, advanced after yaw TERM.
// TESTING
//  1 Reset, then one sample d_ptch=0x0100, ptch=0, all else 0, vld at N
//    -> terms_vld at N+7 only; ptch_pterm=0x0A0 (160), ptch_dterm=0x1B9 (441), roll/yaw terms 0.
//  2 d_yaw=-1000, yaw=0
//    -> yaw_pterm=-320 (0x2C0), yaw_dterm=-448 (0xE40); saturation of err and diff both exercised.
//  3 Thirteen identical samples from test 1
//    -> samples 2..12 ptch_dterm=441; sample 13 ptch_dterm=0 (prev_err=256); pterm=160 throughout.
//  4 vld at N, N+2, N+3
//    -> ovr=1 after N+3; terms_vld at N+7 and N+14 only; second result uses the N+3 data.
//  5 vld at N, clr_hist at N+4
//    -> no terms_vld, busy=0 at N+5, outputs unchanged; next sample yields dterm from prev_err=0.
//  6 rst asserted mid-run at N+3
//    -> next cycle all outputs 0, busy=0, ovr=0; a later sample behaves as first after reset.

Source files
------------

// File: rtl/flght_pkg.sv
// Shared types and widths for the PD axis scheduler.
package flght_pkg;

  localparam int unsigned ANG_W   = 16;
  localparam int unsigned RAW_W   = 17;
  localparam int unsigned ERR_W   = 10;
  localparam int unsigned PTERM_W = 10;
  localparam int unsigned DRAW_W  = 11;
  localparam int unsigned DIFF_W  = 7;
  localparam int unsigned DTERM_W = 12;
  localparam int unsigned N_AX    = 3;

  localparam int ERR_MAX  = 511;
  localparam int ERR_MIN  = -512;
  localparam int DIFF_MAX = 63;
  localparam int DIFF_MIN = -64;

  typedef enum logic [1:0] {
    AX_PTCH = 2'd0,
    AX_ROLL = 2'd1,
    AX_YAW  = 2'd2
  } axis_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR  = 2'd1,
    ST_TERM = 2'd2,
    ST_DONE = 2'd3
  } sched_state_t;

  // Desired/actual angle snapshot; index 0=ptch, 1=roll, 2=yaw.
  typedef struct packed {
    logic [N_AX-1:0][ANG_W-1:0] des;
    logic [N_AX-1:0][ANG_W-1:0] act;
  } snap_t;

endpackage

// File: rtl/pd_axis_math.sv
// Combinational PD arithmetic for one axis: saturated error, P term and D term.
module pd_axis_math
  import flght_pkg::*;
#(
  parameter logic signed [4:0] D_COEFF = 5'sd7
) (
  input  logic signed [ANG_W-1:0]   des,
  input  logic signed [ANG_W-1:0]   act,
  input  logic signed [ERR_W-1:0]   prev_err,
  output logic signed [ERR_W-1:0]   err_sat_c,
  output logic signed [PTERM_W-1:0] pterm_c,
  output logic signed [DTERM_W-1:0] dterm_c
);

  localparam logic signed [RAW_W-1:0]  ERR_HI  = RAW_W'(ERR_MAX);
  localparam logic signed [RAW_W-1:0]  ERR_LO  = RAW_W'(ERR_MIN);
  localparam logic signed [DRAW_W-1:0] DIFF_HI = DRAW_W'(DIFF_MAX);
  localparam logic signed [DRAW_W-1:0] DIFF_LO = DRAW_W'(DIFF_MIN);

  logic signed [RAW_W-1:0]   err_raw;
  logic signed [DRAW_W-1:0]  diff_raw;
  logic signed [DIFF_W-1:0]  diff_sat;
  logic signed [DTERM_W-1:0] diff_ext;
  logic signed [DTERM_W-1:0] coeff_ext;

  // Error, saturation, 5/8 P scaling and D difference times coefficient.
  always_comb begin
    err_raw = $signed({des[ANG_W-1], des}) - $signed({act[ANG_W-1], act});
    if (err_raw > ERR_HI)      err_sat_c = ERR_W'(ERR_MAX);
    else if (err_raw < ERR_LO) err_sat_c = ERR_W'(ERR_MIN);
    else                       err_sat_c = ERR_W'(err_raw);

    pterm_c = (err_sat_c >>> 1) + (err_sat_c >>> 3);

    diff_raw = $signed({err_sat_c[ERR_W-1], err_sat_c}) - $signed({prev_err[ERR_W-1], prev_err});
    if (diff_raw > DIFF_HI)      diff_sat = DIFF_W'(DIFF_MAX);
    else if (diff_raw < DIFF_LO) diff_sat = DIFF_W'(DIFF_MIN);
    else                         diff_sat = DIFF_W'(diff_raw);

    diff_ext  = DTERM_W'(diff_sat);
    coeff_ext = DTERM_W'(D_COEFF);
    dterm_c   = diff_ext * coeff_ext;
  end

endmodule

// File: rtl/pd_axis_sched.sv
// Schedules one shared PD unit over pitch, roll and yaw per inertial sample,
// keeping a per-axis error history for the D term.
module pd_axis_sched
  import flght_pkg::*;
#(
  parameter int unsigned       D_QUEUE_DEPTH = 12,
  parameter logic signed [4:0] D_COEFF       = 5'sd7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vld,
  input  logic                      clr_hist,
  input  logic signed [ANG_W-1:0]   d_ptch,
  input  logic signed [ANG_W-1:0]   d_roll,
  input  logic signed [ANG_W-1:0]   d_yaw,
  input  logic signed [ANG_W-1:0]   ptch,
  input  logic signed [ANG_W-1:0]   roll,
  input  logic signed [ANG_W-1:0]   yaw,
  output logic signed [PTERM_W-1:0] ptch_pterm,
  output logic signed [PTERM_W-1:0] roll_pterm,
  output logic signed [PTERM_W-1:0] yaw_pterm,
  output logic signed [DTERM_W-1:0] ptch_dterm,
  output logic signed [DTERM_W-1:0] roll_dterm,
  output logic signed [DTERM_W-1:0] yaw_dterm,
  output logic                      terms_vld,
  output logic                      busy,
  output logic                      ovr
);

  localparam int unsigned PTR_W = $clog2(D_QUEUE_DEPTH);

  sched_state_t state_q, state_d;
  axis_t        ax_q, ax_d;
  snap_t        snap_q, snap_d, pend_q, pend_d, snap_in;
  logic         pend_vld_q, pend_vld_d;
  logic         ovr_q, ovr_d;
  logic         terms_vld_q, terms_vld_d;
  logic         busy_q, busy_d;
  logic [ERR_W-1:0] prev_q, prev_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [N_AX-1:0][PTERM_W-1:0] res_p_q, res_p_d, out_p_q, out_p_d;
  logic [N_AX-1:0][DTERM_W-1:0] res_d_q, res_d_d, out_d_q, out_d_d;
  logic [ERR_W-1:0] hist_q [N_AX][D_QUEUE_DEPTH];
  logic [ERR_W-1:0] hist_d [N_AX][D_QUEUE_DEPTH];

  logic signed [ANG_W-1:0]   des_c, act_c;
  logic signed [ERR_W-1:0]   err_sat_c;
  logic signed [PTERM_W-1:0] pterm_c;
  logic signed [DTERM_W-1:0] dterm_c;

  // Current axis operands from the snapshot.
  assign des_c = snap_q.des[ax_q];
  assign act_c = snap_q.act[ax_q];

  pd_axis_math #(.D_COEFF(D_COEFF)) u_math (
    .des      (des_c),
    .act      (act_c),
    .prev_err (prev_q),
    .err_sat_c(err_sat_c),
    .pterm_c  (pterm_c),
    .dterm_c  (dterm_c)
  );

  // Next-state: sequencing, pending capture, history pushes and output update.
  always_comb begin
    state_d     = state_q;
    ax_d        = ax_q;
    snap_d      = snap_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    ovr_d       = ovr_q;
    terms_vld_d = 1'b0;
    prev_d      = prev_q;
    wptr_d      = wptr_q;
    res_p_d     = res_p_q;
    res_d_d     = res_d_q;
    out_p_d     = out_p_q;
    out_d_d     = out_d_q;
    hist_d      = hist_q;

    snap_in.des[0] = d_ptch;
    snap_in.des[1] = d_roll;
    snap_in.des[2] = d_yaw;
    snap_in.act[0] = ptch;
    snap_in.act[1] = roll;
    snap_in.act[2] = yaw;

    if (clr_hist) begin
      state_d    = ST_IDLE;
      ax_d       = AX_PTCH;
      pend_vld_d = 1'b0;
      wptr_d     = '0;
      for (int a = 0; a < int'(N_AX); a++) begin
        for (int i = 0; i < int'(D_QUEUE_DEPTH); i++) begin
          hist_d[a][i] = '0;
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vld) begin
            snap_d  = snap_in;
            ax_d    = AX_PTCH;
            state_d = ST_ERR;
          end
        end
        ST_ERR: begin
          prev_d  = hist_q[ax_q][wptr_q];
          state_d = ST_TERM;
          if (vld) begin
            pend_d     = snap_in;
            pend_vld_d = 1'b1;
            if (pend_vld_q) ovr_d = 1'b1;
          end
        end
        ST_TERM: begin
          res_p_d[ax_q]         = pterm_c;
          res_d_d[ax_q]         = dterm_c;
          hist_d[ax_q][wptr_q]  = err_sat_c;
          if (ax_q == AX_YAW) begin
            wptr_d      = (wptr_q == PTR_W'(D_QUEUE_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
            out_p_d     = res_p_q;
            out_d_d     = res_d_q;
            out_p_d[2]  = pterm_c;
            out_d_d[2]  = dterm_c;
            terms_vld_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            ax_d    = axis_t'(ax_q + 2'd1);
            state_d = ST_ERR;
          end
          if (vld) begin
            pend_d     = snap_in;
            pend_vld_d = 1'b1;
            if (pend_vld_q) ovr_d = 1'b1;
          end
        end
        ST_DONE: begin
          // The pending slot is consumed here; a vld this cycle refills it
          // or, if nothing was pending, starts directly.
          ax_d = AX_PTCH;
          if (pend_vld_q) begin
            snap_d     = pend_q;
            pend_vld_d = vld;
            if (vld) pend_d = snap_in;
            state_d    = ST_ERR;
          end else if (vld) begin
            snap_d  = snap_in;
            state_d = ST_ERR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ax_q        <= AX_PTCH;
      snap_q      <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      ovr_q       <= 1'b0;
      terms_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      prev_q      <= '0;
      wptr_q      <= '0;
      res_p_q     <= '0;
      res_d_q     <= '0;
      out_p_q     <= '0;
      out_d_q     <= '0;
      for (int a = 0; a < int'(N_AX); a++) begin
        for (int i = 0; i < int'(D_QUEUE_DEPTH); i++) begin
          hist_q[a][i] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      ax_q        <= ax_d;
      snap_q      <= snap_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      ovr_q       <= ovr_d;
      terms_vld_q <= terms_vld_d;
      busy_q      <= busy_d;
      prev_q      <= prev_d;
      wptr_q      <= wptr_d;
      res_p_q     <= res_p_d;
      res_d_q     <= res_d_d;
      out_p_q     <= out_p_d;
      out_d_q     <= out_d_d;
      hist_q      <= hist_d;
    end
  end

  assign ptch_pterm = out_p_q[0];
  assign roll_pterm = out_p_q[1];
  assign yaw_pterm  = out_p_q[2];
  assign ptch_dterm = out_d_q[0];
  assign roll_dterm = out_d_q[1];
  assign yaw_dterm  = out_d_q[2];
  assign terms_vld  = terms_vld_q;
  assign busy       = busy_q;
  assign ovr        = ovr_q;

endmodule
